ttl_163_chain_sequencer: RTL and testbench

//  Sequencer for a cascade of 163-style synchronous counters (WIDTH bits total) that forms a programmable-modulus divider.

---
 rtl/ttl_163_chain_sequencer.sv | 129 ++++++++++++
 tb/tb_ttl_163_chain_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_163_chain_sequencer.sv
// Sequencer for a cascade of 163-style counters forming a programmable-modulus divider (modulus = 2^WIDTH - preset).
// Latency: chain controls are combinational from state/RCO; state, Wrap and Wrap_Count update on the Cen tick edge.
// Backpressure: Cfg_Ready drops while a preset is pending and rises on the wrap that consumes it. Optional TTL_SEQ_ONESHOT_EN adds Oneshot.
module ttl_163_chain_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Cen,
    input  logic             Start,
    input  logic             Stop,
`ifdef TTL_SEQ_ONESHOT_EN
    input  logic             Oneshot,
`endif
    input  logic             Cfg_Valid,
    input  logic [WIDTH-1:0] Cfg_Preset,
    output logic             Cfg_Ready,
    output logic             Load_bar,
    output logic             ENT,
    output logic             ENP,
    output logic [WIDTH-1:0] D,
    input  logic             RCO,
    output logic             Busy,
    output logic             Wrap,
    output logic [CNT_W-1:0] Wrap_Count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_cen;
    logic             tick;
    logic             wrap_tick;
    logic             to_idle;
    logic             cfg_acc;
    logic             oneshot_hit;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] pending;
    logic             pending_vld;

`ifdef TTL_SEQ_ONESHOT_EN
    assign oneshot_hit = Oneshot;
`else
    assign oneshot_hit = 1'b0;
`endif

    assign tick      = Cen & ~last_cen;
    assign wrap_tick = tick & (state == ST_RUN) & RCO;
    assign to_idle   = tick & (state != ST_IDLE) & (state_nxt == ST_IDLE);
    assign Cfg_Ready = ~pending_vld;
    assign cfg_acc   = Cfg_Valid & Cfg_Ready;
    assign Busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        Load_bar  = 1'b1;
        ENT       = 1'b0;
        ENP       = 1'b0;
        D         = active;
        case (state)
            ST_IDLE: begin
                if (tick && Start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                Load_bar = 1'b0;
                if (tick) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Reload is driven by the chain's own terminal count.
                ENT      = 1'b1;
                ENP      = 1'b1;
                Load_bar = ~RCO;
                D        = pending_vld ? pending : active;
                if (tick) begin
                    if (RCO && oneshot_hit) state_nxt = ST_IDLE;
                    else if (Stop)          state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (tick) begin
                    if (Stop)       state_nxt = ST_IDLE;
                    else if (Start) state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            last_cen    <= 1'b1;
            active      <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            Wrap        <= 1'b0;
            Wrap_Count  <= '0;
        end else begin
            state    <= state_nxt;
            last_cen <= Cen;
            Wrap     <= wrap_tick;
            if (wrap_tick)
                Wrap_Count <= Wrap_Count + CNT_W'(1);
            else if (tick && (state == ST_IDLE) && Start)
                Wrap_Count <= '0;
            // A pending preset never lingers into IDLE, so Ready stays high there.
            if ((wrap_tick || to_idle) && pending_vld) begin
                active      <= pending;
                pending_vld <= 1'b0;
            end
            if (cfg_acc) begin
                if ((state == ST_IDLE) || to_idle) begin
                    active <= Cfg_Preset;
                end else begin
                    pending     <= Cfg_Preset;
                    pending_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ttl_163_chain_sequencer.sv
// Bench for ttl_163_chain_sequencer: behavioural 8-bit 163 chain, table vectors, hand corner cases and a randomized run.
module tb_ttl_163_chain_sequencer;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          Clk        = 1'b0;
    logic          Reset      = 1'b1;
    logic          Cen        = 1'b0;
    logic          Start      = 1'b0;
    logic          Stop       = 1'b0;
    logic          Cfg_Valid  = 1'b0;
    logic [W-1:0]  Cfg_Preset = '0;
`ifdef TTL_SEQ_ONESHOT_EN
    logic          Oneshot    = 1'b0;
`endif
    logic          Cfg_Ready;
    logic          Load_bar;
    logic          ENT;
    logic          ENP;
    logic [W-1:0]  D;
    logic          RCO;
    logic          Busy;
    logic          Wrap;
    logic [CW-1:0] Wrap_Count;

    logic [W-1:0]  cq    = 8'h00;
    logic          cen_q = 1'b1;
    logic          last_wrap = 1'b0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic       st;
        logic       sp;
        logic [7:0] q;
        logic       w;
        logic [7:0] cnt;
        logic       busy;
    } vec_t;
    vec_t tbl[20];

    logic [7:0] m_q;
    logic [7:0] m_act;
    logic [7:0] m_pend;
    logic       m_pv;
    logic [7:0] m_cnt;

    ttl_163_chain_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Cen        (Cen),
        .Start      (Start),
        .Stop       (Stop),
`ifdef TTL_SEQ_ONESHOT_EN
        .Oneshot    (Oneshot),
`endif
        .Cfg_Valid  (Cfg_Valid),
        .Cfg_Preset (Cfg_Preset),
        .Cfg_Ready  (Cfg_Ready),
        .Load_bar   (Load_bar),
        .ENT        (ENT),
        .ENP        (ENP),
        .D          (D),
        .RCO        (RCO),
        .Busy       (Busy),
        .Wrap       (Wrap),
        .Wrap_Count (Wrap_Count)
    );

    always #5 Clk = ~Clk;

    // Behavioural counter chain clocked by the Cen rising edge.
    always @(posedge Clk) begin
        cen_q <= Cen;
        if (Cen && !cen_q) begin
            if (!Load_bar)       cq <= D;
            else if (ENT && ENP) cq <= cq + 8'd1;
        end
    end
    assign RCO = ENT & (cq == 8'hFF);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick_step(input logic st, input logic sp, input logic cv, input logic [7:0] cp);
        Start = st; Stop = sp; Cfg_Valid = cv; Cfg_Preset = cp; Cen = 1'b1;
        @(negedge Clk);
        last_wrap = Wrap;
        Start = 1'b0; Stop = 1'b0; Cfg_Valid = 1'b0;
        @(negedge Clk);
        Cen = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic tk();
        tick_step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic offer(input logic [7:0] v);
        Cfg_Valid = 1'b1; Cfg_Preset = v;
        @(negedge Clk);
        Cfg_Valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; Cen = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int r;
        logic [7:0] v;
        logic ot;
        logic rdy_b;

        // Table: start from IDLE with preset FA, then 19 free-running ticks (period 6).
        tbl[0] = '{st: 1'b1, sp: 1'b0, q: 8'h00, w: 1'b0, cnt: 8'd0, busy: 1'b1};
        for (int i = 1; i < 20; i++) begin
            tbl[i].st   = 1'b0;
            tbl[i].sp   = 1'b0;
            tbl[i].q    = 8'(250 + (i - 1) % 6);
            tbl[i].w    = ((i - 1) % 6 == 0) && (i > 1);
            tbl[i].cnt  = 8'((i - 1) / 6);
            tbl[i].busy = 1'b1;
        end

        do_reset();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_loadbar", 32'(Load_bar), 1);
        chk("rst_ent", 32'(ENT), 0);
        chk("rst_cnt", 32'(Wrap_Count), 0);
        chk("rst_ready", 32'(Cfg_Ready), 1);
        chk("rst_wrap", 32'(Wrap), 0);

        offer(8'hFA);
        chk("idle_ready_held", 32'(Cfg_Ready), 1);
        chk("idle_d_active", 32'(D), 'hFA);

        for (int i = 0; i < 20; i++) begin
            tick_step(tbl[i].st, tbl[i].sp, 1'b0, 8'h00);
            chk("tbl_q", 32'(cq), 32'(tbl[i].q));
            chk("tbl_wrap", 32'(last_wrap), 32'(tbl[i].w));
            chk("tbl_cnt", 32'(Wrap_Count), 32'(tbl[i].cnt));
            chk("tbl_busy", 32'(Busy), 32'(tbl[i].busy));
        end

        // Preset update mid-period.
        chk("upd_ready_before", 32'(Cfg_Ready), 1);
        offer(8'hF0);
        chk("upd_ready_drop", 32'(Cfg_Ready), 0);
        repeat (5) tk();
        chk("upd_q_ff", 32'(cq), 'hFF);
        chk("upd_ready_still0", 32'(Cfg_Ready), 0);
        tk();
        chk("upd_q_reload", 32'(cq), 'hF0);
        chk("upd_wrap", 32'(last_wrap), 1);
        chk("upd_ready_rise", 32'(Cfg_Ready), 1);
        chk("upd_cnt", 32'(Wrap_Count), 4);
        nw = 0;
        repeat (16) begin tk(); nw += int'(last_wrap); end
        chk("period16_wraps", nw, 1);
        chk("period16_q", 32'(cq), 'hF0);

        // Offer on the exact Clk of a wrap tick.
        repeat (15) tk();
        chk("edge_q_ff", 32'(cq), 'hFF);
        tick_step(1'b0, 1'b0, 1'b1, 8'hFC);
        chk("edge_old_preset", 32'(cq), 'hF0);
        chk("edge_ready0", 32'(Cfg_Ready), 0);
        repeat (15) tk();
        tk();
        chk("edge_new_preset", 32'(cq), 'hFC);
        chk("edge_cnt", 32'(Wrap_Count), 7);
        chk("edge_ready1", 32'(Cfg_Ready), 1);

        // Pause and resume, then stop twice to IDLE.
        tick_step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pause_q", 32'(cq), 'hFD);
        nw = 0;
        repeat (4) begin tk(); nw += int'(last_wrap); end
        chk("pause_frozen", 32'(cq), 'hFD);
        chk("pause_nowrap", nw, 0);
        chk("pause_ent", 32'(ENT), 0);
        chk("pause_busy", 32'(Busy), 1);
        tick_step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("resume_hold", 32'(cq), 'hFD);
        tk(); chk("resume_fe", 32'(cq), 'hFE);
        tk(); chk("resume_ff", 32'(cq), 'hFF);
        tk(); chk("resume_reload", 32'(cq), 'hFC);
        chk("resume_cnt", 32'(Wrap_Count), 8);
        tick_step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("stop2_busy", 32'(Busy), 0);
        chk("stop2_q", 32'(cq), 'hFD);
        chk("stop2_loadbar", 32'(Load_bar), 1);

        // Modulus 1.
        offer(8'hFF);
        chk("m1_d", 32'(D), 'hFF);
        tick_step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("m1_cnt_clear", 32'(Wrap_Count), 0);
        tk();
        chk("m1_loaded", 32'(cq), 'hFF);
        nw = 0;
        repeat (4) begin tk(); nw += int'(last_wrap); end
        chk("m1_wraps", nw, 4);
        chk("m1_q", 32'(cq), 'hFF);
        chk("m1_cnt", 32'(Wrap_Count), 4);

        // Reset while running.
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", 32'(Busy), 0);
        chk("midrst_cnt", 32'(Wrap_Count), 0);
        chk("midrst_loadbar", 32'(Load_bar), 1);
        Reset = 1'b0;
        @(negedge Clk);

`ifdef TTL_SEQ_ONESHOT_EN
        offer(8'hFE);
        Oneshot = 1'b1;
        tick_step(1'b1, 1'b0, 1'b0, 8'h00);
        tk();
        chk("os_load", 32'(cq), 'hFE);
        nw = 0;
        repeat (2) begin tk(); nw += int'(last_wrap); end
        chk("os_one_wrap", nw, 1);
        chk("os_idle", 32'(Busy), 0);
        repeat (3) begin tk(); nw += int'(last_wrap); end
        chk("os_no_more", nw, 1);
        chk("os_q_held", 32'(cq), 'hFE);
        Oneshot = 1'b0;
`endif

        // Randomized free run against a preset-queue reference model.
        do_reset();
        v = 8'($urandom_range(8'hF0, 8'hFF));
        offer(v);
        tick_step(1'b1, 1'b0, 1'b0, 8'h00);
        tk();
        m_q = v; m_act = v; m_pend = 8'h00; m_pv = 1'b0; m_cnt = 8'h00;
        chk("rnd_start", 32'(cq), 32'(m_q));
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                chk("rnd_ready_mid", 32'(Cfg_Ready), 32'(!m_pv));
                v = 8'($urandom_range(8'hF0, 8'hFF));
                offer(v);
                if (!m_pv) begin m_pend = v; m_pv = 1'b1; end
            end
            ot = (r == 1);
            v = 8'($urandom_range(8'hF0, 8'hFF));
            rdy_b = !m_pv;
            if (ot) chk("rnd_ready_tick", 32'(Cfg_Ready), 32'(rdy_b));
            tick_step(1'b0, 1'b0, ot, v);
            if (m_q == 8'hFF) begin
                m_q = m_pv ? m_pend : m_act;
                if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
                m_cnt = m_cnt + 8'd1;
                chk("rnd_wrap", 32'(last_wrap), 1);
            end else begin
                m_q = m_q + 8'd1;
                chk("rnd_wrap", 32'(last_wrap), 0);
            end
            if (ot && rdy_b) begin m_pend = v; m_pv = 1'b1; end
            chk("rnd_q", 32'(cq), 32'(m_q));
            chk("rnd_cnt", 32'(Wrap_Count), 32'(m_cnt));
            chk("rnd_ready", 32'(Cfg_Ready), 32'(!m_pv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
